// File: rtl/sram_device_if.sv
// rtl/sram_device_if.sv - RAM_IF request/acknowledge bundle between a UMA host port and a memory device
// Signals:
//   ADDR[23:0]  byte address           DIN[15:0]  write data
//   DIN_SIZE    0 = byte, 1 = word     OE_n/WE_n/RFSH_n  request strobes (falling edge = request)
//   DOUT[15:0]  read data              ACK_n      low while the device is serving a request
interface RAM_IF;
    logic [23:0] ADDR;
    logic [15:0] DIN;
    logic        DIN_SIZE;
    logic        OE_n;
    logic        WE_n;
    logic        RFSH_n;
    logic [15:0] DOUT;
    logic        ACK_n;

    modport DEVICE (
        input  ADDR, DIN, DIN_SIZE, OE_n, WE_n, RFSH_n,
        output DOUT, ACK_n
    );

    modport HOST (
        output ADDR, DIN, DIN_SIZE, OE_n, WE_n, RFSH_n,
        input  DOUT, ACK_n
    );
endinterface

// File: rtl/sram_device.sv
// rtl/sram_device.sv - RAM_IF responder running each host request as one access on an async 16-bit SRAM
// Ports:
//   CLK, RESET        clock (rising edge) and asynchronous active-high reset
//   Ram               RAM_IF.DEVICE request port (strobes in, DOUT/ACK_n out)
//   SRAM_A            SRAM word address (byte address bits [SRAM_AW:1])
//   SRAM_DQ           SRAM data bus, driven only from write start through the recovery cycle
//   SRAM_CE_n/OE_n/WE_n/LB_n/UB_n  active-low SRAM controls
module sram_device #(
    parameter int SRAM_AW   = 19,
    parameter int RD_WAIT   = 2,
    parameter int WR_WAIT   = 2,
    parameter int RFSH_WAIT = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    RAM_IF.DEVICE              Ram,
    output logic [SRAM_AW-1:0] SRAM_A,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_CE_n,
    output logic               SRAM_OE_n,
    output logic               SRAM_WE_n,
    output logic               SRAM_LB_n,
    output logic               SRAM_UB_n
);
    localparam int CW = 8;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_RFSH, S_RECOVER} state_t;
    typedef enum logic [1:0] {K_RD, K_WR, K_RF} kind_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            oe_prev, we_prev, rfsh_prev;
    logic            cur_size, cur_a0;
    logic            dq_oe;
    logic [15:0]     dq_out;

    logic            pend_valid;
    kind_t           pend_kind;
    logic [SRAM_AW:0] pend_addr;
    logic [15:0]     pend_din;
    logic            pend_size;

    logic            edge_oe, edge_we, edge_rf, edge_any;
    kind_t           edge_kind;
    logic            go;
    kind_t           go_kind;
    logic [SRAM_AW:0] go_addr;
    logic [15:0]     go_din;
    logic            go_size;

    // High address bits beyond the SRAM are ignored so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^Ram.ADDR[23:SRAM_AW+1];

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    always_comb begin
        edge_we   = we_prev & ~Ram.WE_n;
        edge_oe   = oe_prev & ~Ram.OE_n;
        edge_rf   = rfsh_prev & ~Ram.RFSH_n;
        edge_any  = edge_we | edge_oe | edge_rf;
        edge_kind = K_RF;
        if (edge_we)      edge_kind = K_WR;
        else if (edge_oe) edge_kind = K_RD;
    end

    // In IDLE a stored request wins; a fresh edge in that same cycle is dropped.
    always_comb begin
        go      = 1'b0;
        go_kind = edge_kind;
        go_addr = Ram.ADDR[SRAM_AW:0];
        go_din  = Ram.DIN;
        go_size = Ram.DIN_SIZE;
        if (state == S_IDLE) begin
            if (pend_valid) begin
                go      = 1'b1;
                go_kind = pend_kind;
                go_addr = pend_addr;
                go_din  = pend_din;
                go_size = pend_size;
            end else if (edge_any) begin
                go = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            oe_prev    <= 1'b1;
            we_prev    <= 1'b1;
            rfsh_prev  <= 1'b1;
            cur_size   <= 1'b0;
            cur_a0     <= 1'b0;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            pend_valid <= 1'b0;
            pend_kind  <= K_RF;
            pend_addr  <= '0;
            pend_din   <= '0;
            pend_size  <= 1'b0;
            Ram.ACK_n  <= 1'b1;
            Ram.DOUT   <= '0;
            SRAM_A     <= '0;
            SRAM_CE_n  <= 1'b1;
            SRAM_OE_n  <= 1'b1;
            SRAM_WE_n  <= 1'b1;
            SRAM_LB_n  <= 1'b1;
            SRAM_UB_n  <= 1'b1;
        end else begin
            oe_prev   <= Ram.OE_n;
            we_prev   <= Ram.WE_n;
            rfsh_prev <= Ram.RFSH_n;

            if (state != S_IDLE && edge_any && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_kind  <= edge_kind;
                pend_addr  <= Ram.ADDR[SRAM_AW:0];
                pend_din   <= Ram.DIN;
                pend_size  <= Ram.DIN_SIZE;
            end

            case (state)
                S_IDLE: begin
                    if (go) begin
                        pend_valid <= 1'b0;
                        Ram.ACK_n  <= 1'b0;
                        cur_size   <= go_size;
                        cur_a0     <= go_addr[0];
                        if (go_kind == K_RF) begin
                            cnt   <= CW'(RFSH_WAIT - 1);
                            state <= S_RFSH;
                        end else begin
                            SRAM_A    <= go_addr[SRAM_AW:1];
                            SRAM_CE_n <= 1'b0;
                            SRAM_LB_n <= ~(go_size | ~go_addr[0]);
                            SRAM_UB_n <= ~(go_size | go_addr[0]);
                            if (go_kind == K_WR) begin
                                cnt       <= CW'(WR_WAIT - 1);
                                SRAM_WE_n <= 1'b0;
                                dq_oe     <= 1'b1;
                                // Byte writes replicate the byte so either lane sees it.
                                dq_out    <= go_size ? go_din : {go_din[7:0], go_din[7:0]};
                                state     <= S_WRITE;
                            end else begin
                                cnt       <= CW'(RD_WAIT - 1);
                                SRAM_OE_n <= 1'b0;
                                state     <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        Ram.DOUT  <= cur_size ? SRAM_DQ :
                                     (cur_a0 ? {8'h00, SRAM_DQ[15:8]} : {8'h00, SRAM_DQ[7:0]});
                        Ram.ACK_n <= 1'b1;
                        SRAM_OE_n <= 1'b1;
                        state     <= S_RECOVER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WRITE: begin
                    if (cnt == '0) begin
                        SRAM_WE_n <= 1'b1;
                        Ram.ACK_n <= 1'b1;
                        state     <= S_RECOVER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RFSH: begin
                    if (cnt == '0) begin
                        Ram.ACK_n <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RECOVER: begin
                    // DQ was held through this cycle to give the SRAM data hold after WE_n rose.
                    SRAM_CE_n <= 1'b1;
                    SRAM_LB_n <= 1'b1;
                    SRAM_UB_n <= 1'b1;
                    dq_oe     <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
